// File: rtl/bch_decoder.sv
// bch_decoder: serial SEC-DED decoder for BCH(63,56), g(x)=x^7+x^6+x^2+1.
// Define BCH_DEC_EARLY_EXIT_EN to leave correction on the matching bit instead of after all 63.
module bch_decoder #(
    parameter int N = 63,
    parameter int K = 56,
    parameter logic [6:0] GLOW = 7'b1000101
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] R,
    input  logic         isEn2,
    output logic [N-1:0] Rc,
    output logic [K-1:0] D,
    output logic [5:0]   Err_Pos,
    output logic         Corrected,
    output logic         Uncorrectable,
    output logic         Decode_Done
);
    typedef enum logic [2:0] {IDLE, SYND, EVAL, CORR, DONE} state_t;

    state_t       state_q;
    logic [N-1:0] rc_q;
    logic [6:0]   s_q, p_q;
    logic [5:0]   cnt_q, pos_q;
    logic         par_q, corr_q, unc_q, done_q;
    logic         bit_w, hit_w, exit_w;

    assign bit_w = rc_q[cnt_q];
    // p walks x^j mod g(x); a single error at j leaves exactly that value in s
    assign hit_w = (p_q == s_q) && !corr_q;
`ifdef BCH_DEC_EARLY_EXIT_EN
    assign exit_w = hit_w || (cnt_q == 6'd62);
`else
    assign exit_w = (cnt_q == 6'd62);
`endif

    assign Rc            = rc_q;
    assign D             = rc_q[N-1:N-K];
    assign Err_Pos       = pos_q;
    assign Corrected     = corr_q;
    assign Uncorrectable = unc_q;
    assign Decode_Done   = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rc_q    <= '0;
            s_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            par_q   <= 1'b0;
            corr_q  <= 1'b0;
            unc_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (isEn2) begin
                    rc_q    <= R;
                    s_q     <= '0;
                    par_q   <= 1'b0;
                    cnt_q   <= 6'd62;
                    pos_q   <= '0;
                    corr_q  <= 1'b0;
                    unc_q   <= 1'b0;
                    state_q <= SYND;
                end
                SYND: begin
                    s_q   <= {s_q[5:0], bit_w} ^ (s_q[6] ? GLOW : 7'd0);
                    par_q <= par_q ^ bit_w;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd0) state_q <= EVAL;
                end
                EVAL: begin
                    if (s_q == 7'd0 || !par_q) begin
                        unc_q   <= (s_q != 7'd0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        p_q     <= 7'd1;
                        cnt_q   <= 6'd0;
                        state_q <= CORR;
                    end
                end
                CORR: begin
                    if (hit_w) begin
                        rc_q[cnt_q] <= ~rc_q[cnt_q];
                        pos_q       <= cnt_q;
                        corr_q      <= 1'b1;
                    end
                    p_q   <= {p_q[5:0], 1'b0} ^ (p_q[6] ? GLOW : 7'd0);
                    cnt_q <= cnt_q + 6'd1;
                    if (exit_w) begin
                        unc_q   <= !(corr_q || hit_w);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: if (!isEn2) begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bch_decoder.sv
// tb_bch_decoder: directed vector table plus handshake, mid-operation and reset sequences.
module tb_bch_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [62:0] R;
    logic        isEn2;
    logic [62:0] Rc;
    logic [55:0] D;
    logic [5:0]  Err_Pos;
    logic        Corrected, Uncorrectable, Decode_Done;

    int tests = 0;
    int fails = 0;

    bch_decoder dut (
        .clk(clk), .rst_n(rst_n), .R(R), .isEn2(isEn2), .Rc(Rc), .D(D),
        .Err_Pos(Err_Pos), .Corrected(Corrected), .Uncorrectable(Uncorrectable),
        .Decode_Done(Decode_Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [62:0] r;
        logic [62:0] rc;
        logic [5:0]  pos;
        logic        c;
        logic        u;
        int          lat;
    } vec_t;

    function automatic int lat_corr(input int j);
`ifdef BCH_DEC_EARLY_EXIT_EN
        return 65 + j;
`else
        return 127;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int hold);
        int lat;
        @(negedge clk);
        R = v.r;
        isEn2 = 1'b1;
        lat = -1;
        for (int e = 0; e < 200; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) R = ~v.r;
            if (Decode_Done) begin
                lat = e;
                break;
            end
        end
        chk("latency", lat, v.lat);
        repeat (hold) @(posedge clk);
        #1;
        chk("done_held", Decode_Done, 1'b1);
        chk("rc", Rc, v.rc);
        chk("d", D, v.rc[62:7]);
        chk("corrected", Corrected, v.c);
        chk("uncorrectable", Uncorrectable, v.u);
        if (v.c) chk("err_pos", Err_Pos, v.pos);
        chk("flags_exclusive", Corrected & Uncorrectable, 1'b0);
        @(negedge clk);
        isEn2 = 1'b0;
        @(posedge clk);
        #1;
        chk("done_drop", Decode_Done, 1'b0);
        chk("rc_after_drop", Rc, v.rc);
        chk("corr_after_drop", Corrected, v.c);
    endtask

    vec_t tbl[9];
    logic [62:0] cw;

    initial begin
        cw = 63'hC5 << 20;
        tbl[0] = '{63'h0, 63'h0, 6'd0, 1'b0, 1'b0, 64};
        tbl[1] = '{63'hC5, 63'hC5, 6'd0, 1'b0, 1'b0, 64};
        tbl[2] = '{63'h1, 63'h0, 6'd0, 1'b1, 1'b0, lat_corr(0)};
        tbl[3] = '{63'h3, 63'h3, 6'd0, 1'b0, 1'b1, 64};
        tbl[4] = '{63'h1 << 62, 63'h0, 6'd62, 1'b1, 1'b0, 127};
        tbl[5] = '{63'hC5 ^ (63'h1 << 10), 63'hC5, 6'd10, 1'b1, 1'b0, lat_corr(10)};
        tbl[6] = '{cw ^ (63'h1 << 40), cw, 6'd40, 1'b1, 1'b0, lat_corr(40)};
        tbl[7] = '{cw ^ (63'h1 << 3) ^ (63'h1 << 50), cw ^ (63'h1 << 3) ^ (63'h1 << 50),
                   6'd0, 1'b0, 1'b1, 64};
        tbl[8] = '{63'hC5 ^ (63'h1 << 7), 63'hC5, 6'd7, 1'b1, 1'b0, lat_corr(7)};

        rst_n = 1'b0;
        isEn2 = 1'b0;
        R = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rc", Rc, 63'h0);
        chk("reset_done", Decode_Done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run(tbl[i], (i == 1) ? 10 : 0);

        // isEn2 dropped mid-decode: the operation still finishes and keeps its results
        @(negedge clk);
        R = 63'h1 << 5;
        isEn2 = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        isEn2 = 1'b0;
        repeat (140) @(posedge clk);
        #1;
        chk("midop_corrected", Corrected, 1'b1);
        chk("midop_pos", Err_Pos, 6'd5);
        chk("midop_rc", Rc, 63'h0);
        chk("midop_done", Decode_Done, 1'b0);

        // asynchronous reset at t30 of a decode
        @(negedge clk);
        R = 63'h1 << 62;
        isEn2 = 1'b1;
        repeat (31) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_rc", Rc, 63'h0);
        chk("rst_d", D, 56'h0);
        chk("rst_pos", Err_Pos, 6'd0);
        chk("rst_corr", Corrected, 1'b0);
        chk("rst_unc", Uncorrectable, 1'b0);
        chk("rst_done", Decode_Done, 1'b0);
        isEn2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(tbl[2], 0);
        run(tbl[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
